// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream with burst framing; rd_en->m_valid latency 2 cycles.
// Backpressure: m_ready low holds m_data/m_last; reads stop once buffer plus in-flight word reach 3.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  output logic                         fifo_rd_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic [$clog2(BURST_LEN):0]   beat_cnt
);

  localparam int              CW        = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [2:0]      SLOTS     = 3'(BUF_DEPTH);
  localparam logic [1:0]      LAST_IDX  = 2'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
  logic [1:0]            wr_idx_q, wr_idx_d;
  logic [1:0]            rd_idx_q, rd_idx_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pending_q, pending_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;

  logic [2:0]            level;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    return (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    // Read issue only looks at registered state, so m_ready never reaches fifo_rd_en.
    level      = {1'b0, occ_q} + {2'b00, pending_q};
    fifo_rd_en = !rst && !fifo_empty && (level < SLOTS);

    head = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (rd_idx_q == 2'(i)) head = buf_q[i];
    end

    m_valid  = (occ_q != 2'd0);
    m_data   = head;
    m_last   = m_valid && (beat_cnt_q == LAST_BEAT);
    beat_cnt = beat_cnt_q;

    push = pending_q;
    pop  = m_valid && m_ready;
  end

  always_comb begin
    buf_d      = buf_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    occ_d      = occ_q;
    beat_cnt_d = beat_cnt_q;
    pending_d  = fifo_rd_en;

    if (push) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_idx_q == 2'(i)) buf_d[i] = fifo_rd_data;
      end
      wr_idx_d = idx_next(wr_idx_q);
    end

    if (pop) begin
      rd_idx_d   = idx_next(rd_idx_q);
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      wr_idx_q   <= 2'd0;
      rd_idx_q   <= 2'd0;
      occ_q      <= 2'd0;
      pending_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= buf_d[i];
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      occ_q      <= occ_d;
      pending_q  <= pending_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO models feed two builds (BURST_LEN 4 and 1); a monitor scores every beat.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic [2:0]  beat_cnt;

  logic        fifo_empty1;
  logic [15:0] fifo_rd_data1;
  logic        fifo_rd_en1;
  logic        m_valid1;
  logic        m_ready1;
  logic [15:0] m_data1;
  logic        m_last1;
  logic [0:0]  beat_cnt1;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;

  logic [15:0] fq[$];
  logic [15:0] fq1[$];
  logic [16:0] exp_q[$];
  logic [15:0] exp1[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(16), .BURST_LEN(4), .BUF_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .beat_cnt(beat_cnt)
  );

  fifo_stream_reader #(.DATA_WIDTH(16), .BURST_LEN(1), .BUF_DEPTH(3)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_rd_data(fifo_rd_data1),
    .fifo_rd_en(fifo_rd_en1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
    .m_last(m_last1), .beat_cnt(beat_cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FIFO models: registered read data, valid the cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_rd_data <= fq.pop_front();
      fifo_empty   <= (fq.size() == 0);
    end
    if (fifo_rd_en1 && fq1.size() > 0) begin
      fifo_rd_data1 <= fq1.pop_front();
      fifo_empty1   <= (fq1.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_pulses++;
  end

  task automatic push(input logic [15:0] d, input logic last, input bit scored);
    fq.push_back(d);
    fifo_empty = 1'b0;
    if (scored) exp_q.push_back({last, d});
  endtask

  // Scoreboard monitor for the BURST_LEN=4 build.
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;
  logic [16:0] e;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(stall_data));
        check("hold_last", 32'(m_last), 32'(stall_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(e[15:0]));
          check("beat_last", 32'(m_last), 32'(e[16]));
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      check("occ_bound", 32'(({1'b0, dut.occ_q} + {2'b00, dut.pending_q}) <= 3'd3), 32'd1);
    end
  end

  // Monitor for the BURST_LEN=1 build.
  logic [15:0] e1;
  always @(negedge clk) begin
    if (!rst && m_valid1 && m_ready1) begin
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat1 actual=%0h required=none", m_data1);
      end else begin
        e1 = exp1.pop_front();
        check("b1_data", 32'(m_data1), 32'(e1));
        check("b1_last", 32'(m_last1), 32'd1);
        check("b1_beat_cnt", 32'(beat_cnt1), 32'd0);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit found;
    rst = 1'b1;
    m_ready = 1'b1;
    m_ready1 = 1'b1;
    fifo_empty = 1'b1;
    fifo_empty1 = 1'b1;
    fifo_rd_data = '0;
    fifo_rd_data1 = '0;

    // Streaming at full rate, FIFO loaded during reset.
    repeat (3) @(posedge clk);
    #2;
    for (int i = 1; i <= 8; i++) push(16'(i), (i % 4) == 0, 1'b1);
    @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("first_rd_en", 32'(fifo_rd_en), 32'd1);
    check("lat_valid0", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat_valid1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat_valid2", 32'(m_valid), 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("no_bubble", 32'(m_valid), 32'd1);
    end
    drain();
    check("t1_beat_cnt", 32'(beat_cnt), 32'd0);

    // Stalled consumer: only three reads may be issued.
    m_ready = 1'b0;
    base = rd_pulses;
    for (int i = 1; i <= 8; i++) push(16'(i), (i % 4) == 0, 1'b1);
    repeat (10) @(negedge clk);
    check("stall_rd_pulses", 32'(rd_pulses - base), 32'd3);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_data", 32'(m_data), 32'h0001);
    @(posedge clk);
    #2 m_ready = 1'b1;
    drain();
    check("t2_beat_cnt", 32'(beat_cnt), 32'd0);

    // Alternating ready over 12 words.
    for (int i = 0; i < 12; i++) push(16'hA000 + 16'(i), (i % 4) == 3, 1'b1);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2 m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    drain();
    check("t3_beat_cnt", 32'(beat_cnt), 32'd0);

    // Partial burst, gap, then completion.
    push(16'h0010, 1'b0, 1'b1);
    push(16'h0011, 1'b0, 1'b1);
    drain();
    check("t4_beat_cnt_mid", 32'(beat_cnt), 32'd2);
    repeat (5) @(negedge clk);
    check("t4_gap_valid", 32'(m_valid), 32'd0);
    check("t4_gap_beat_cnt", 32'(beat_cnt), 32'd2);
    @(posedge clk);
    #2;
    push(16'h0012, 1'b0, 1'b1);
    push(16'h0013, 1'b1, 1'b1);
    drain();
    check("t4_beat_cnt_end", 32'(beat_cnt), 32'd0);

    // Reset with a full buffer and a read in flight.
    push(16'h0050, 1'b0, 1'b1);
    drain();
    check("t5_beat_cnt_pre", 32'(beat_cnt), 32'd1);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h0060 + 16'(i), 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dut.occ_q == 2'd2 && dut.pending_q) found = 1'b1;
    end
    check("t5_reach_full", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", 32'(m_valid), 32'd0);
    check("t5_rst_last", 32'(m_last), 32'd0);
    check("t5_rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    fq.delete();
    fifo_empty = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    m_ready = 1'b1;
    push(16'h0100, 1'b0, 1'b1);
    drain();
    check("t5_beat_cnt_post", 32'(beat_cnt), 32'd1);

    // Single-beat bursts.
    for (int i = 1; i <= 3; i++) begin
      fq1.push_back(16'h0200 + 16'(i));
      exp1.push_back(16'h0200 + 16'(i));
    end
    fifo_empty1 = 1'b0;
    for (int i = 0; i < 100 && exp1.size() != 0; i++) @(negedge clk);
    if (exp1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain1_timeout actual=%0d required=0", exp1.size());
    end
    @(posedge clk);
    #2;
    check("t6_beat_cnt", 32'(beat_cnt1), 32'd0);
    check("t6_valid_idle", 32'(m_valid1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
